sync_fifo_fwft: RTL and testbench



---
 rtl/sync_fifo_fwft_pkg.sv | 11 +
 rtl/sync_fifo_fwft_sdp_ram.sv | 31 +++
 rtl/sync_fifo_fwft.sv | 98 +++++++++
 tb/tb_sync_fifo_fwft.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared sizing helpers for the FIFO family (sync and future async variants).
package sync_fifo_fwft_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (block-RAM style).
module sdp_ram
  import sync_fifo_fwft_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with optional first-word-fall-through, exact count and
// registered look-ahead flags.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(DEPTH):0] data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_WIDTH = clog2(DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  logic [CNT_WIDTH-1:0] wr_ptr, rd_ptr, count_next;
  logic                 wr_ok, rd_ok, ram_rd, valid_next, empty_next;

  always_comb begin
    wr_ok      = wr_en & ~full;
    rd_ok      = rd_en & ~empty;
    count_next = data_count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = data_count + CNT_WIDTH'(1);
      2'b01:   count_next = data_count - CNT_WIDTH'(1);
      default: count_next = data_count;
    endcase

    // In FWFT mode the RAM output register is the head register: it is refilled
    // whenever the RAM holds words and the head is either absent or being consumed.
    if (FWFT != 0) begin
      ram_rd     = (wr_ptr != rd_ptr) && (!valid || rd_ok);
      valid_next = ram_rd || (valid && !rd_ok);
      empty_next = !valid_next;
    end else begin
      ram_rd     = rd_ok;
      valid_next = rd_ok;
      empty_next = (count_next == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      valid        <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AFULL_TH == 0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + CNT_WIDTH'(1);
      if (ram_rd) rd_ptr <= rd_ptr + CNT_WIDTH'(1);
      data_count   <= count_next;
      valid        <= valid_next;
      empty        <= empty_next;
      full         <= (count_next == CNT_WIDTH'(DEPTH));
      almost_full  <= (int'(count_next) >= AFULL_TH);
      almost_empty <= (int'(count_next) <= AEMPTY_TH);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end

  sdp_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (din),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: standard and FWFT instances (WIDTH=8, DEPTH=8) against queue models.
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_din, f_din, s_dout, f_dout;
  logic       s_wr, s_rd, f_wr, f_rd;
  logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_cnt, f_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_std (
    .clk(clk), .rst(rst), .din(s_din), .wr_en(s_wr), .rd_en(s_rd), .dout(s_dout),
    .valid(s_valid), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .data_count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)) u_fwft (
    .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr), .rd_en(f_rd), .dout(f_dout),
    .valid(f_valid), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .data_count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Standard-mode model: a queue of stored words; a read returns the head one edge later.
  logic [7:0] ms_q[$];
  logic [7:0] ms_dout = 8'h00;
  logic       ms_valid = 1'b0, ms_ovf = 1'b0, ms_unf = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ms_q.delete();
      ms_dout = 8'h00; ms_valid = 1'b0; ms_ovf = 1'b0; ms_unf = 1'b0;
    end else begin
      bit wok, rok;
      wok      = s_wr && (ms_q.size() < 8);
      rok      = s_rd && (ms_q.size() > 0);
      ms_ovf   = s_wr && (ms_q.size() == 8);
      ms_unf   = s_rd && (ms_q.size() == 0);
      ms_valid = rok;
      if (rok) ms_dout = ms_q.pop_front();
      if (wok) ms_q.push_back(s_din);
    end
  end

  // FWFT model: the head word is visible only at an edge strictly later than its write edge.
  logic [7:0] mf_q[$];
  int         mf_t[$];
  int         mf_edge = 0;
  logic [7:0] mf_dout = 8'h00;
  logic       mf_valid = 1'b0, mf_ovf = 1'b0, mf_unf = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mf_q.delete(); mf_t.delete();
      mf_valid = 1'b0; mf_ovf = 1'b0; mf_unf = 1'b0;
    end else begin
      bit wok, rok;
      wok    = f_wr && (mf_q.size() < 8);
      rok    = f_rd && mf_valid;
      mf_ovf = f_wr && (mf_q.size() == 8);
      mf_unf = f_rd && !mf_valid;
      if (rok) begin void'(mf_q.pop_front()); void'(mf_t.pop_front()); end
      if (wok) begin mf_q.push_back(f_din); mf_t.push_back(mf_edge); end
      mf_valid = (mf_q.size() > 0) && (mf_t[0] < mf_edge);
      if (mf_valid) mf_dout = mf_q[0];
      mf_edge++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("std_count", s_cnt, ms_q.size());
    chk("std_full",  s_full, ms_q.size() == 8);
    chk("std_empty", s_empty, ms_q.size() == 0);
    chk("std_afull", s_af, ms_q.size() >= 6);
    chk("std_aempty", s_ae, ms_q.size() <= 2);
    chk("std_valid", s_valid, ms_valid);
    chk("std_dout",  s_dout, ms_dout);
    chk("std_ovf",   s_ovf, ms_ovf);
    chk("std_unf",   s_unf, ms_unf);
    chk("fw_count",  f_cnt, mf_q.size());
    chk("fw_full",   f_full, mf_q.size() == 8);
    chk("fw_empty",  f_empty, !mf_valid);
    chk("fw_afull",  f_af, mf_q.size() >= 6);
    chk("fw_aempty", f_ae, mf_q.size() <= 2);
    chk("fw_valid",  f_valid, mf_valid);
    if (mf_valid) chk("fw_dout", f_dout, mf_dout);
    chk("fw_ovf",    f_ovf, mf_ovf);
    chk("fw_unf",    f_unf, mf_unf);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives both instances for one edge; returns 1 time unit after that edge.
  task automatic drive(input logic sw, input logic sr, input logic [7:0] sd,
                       input logic fw, input logic fr, input logic [7:0] fd);
    @(negedge clk);
    #2;
    s_wr = sw; s_rd = sr; s_din = sd;
    f_wr = fw; f_rd = fr; f_din = fd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_wr = 0; s_rd = 0; s_din = '0; f_wr = 0; f_rd = 0; f_din = '0;
    @(posedge clk); #1;
    chk("rst_std_count", s_cnt, 0);
    chk("rst_std_empty", s_empty, 1);
    chk("rst_std_full",  s_full, 0);
    chk("rst_std_ae",    s_ae, 1);
    chk("rst_fw_valid",  f_valid, 0);
    @(negedge clk); #2 rst = 1'b0;

    // Fill / overflow / drain, standard mode
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'(i), 0, 0, 0);
      if (i == 4) chk("std_af_at5", s_af, 0);
      if (i == 5) chk("std_af_at6", s_af, 1);
    end
    chk("std_full_at8", s_full, 1);
    chk("std_cnt_at8", s_cnt, 8);
    drive(1, 0, 8'h99, 0, 0, 0);
    chk("std_ovf_pulse", s_ovf, 1);
    chk("std_cnt_ovf", s_cnt, 8);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      chk("std_drain_dout", s_dout, i);
      chk("std_drain_valid", s_valid, 1);
    end
    chk("std_empty_after", s_empty, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("std_valid_idle", s_valid, 0);

    // Underflow, then simultaneous wr/rd on an empty FIFO
    drive(0, 1, 0, 0, 0, 0);
    chk("std_unf_pulse", s_unf, 1);
    chk("std_unf_dout_held", s_dout, 8'h07);
    drive(0, 0, 0, 0, 0, 0);
    chk("std_unf_cleared", s_unf, 0);
    drive(1, 1, 8'h42, 0, 1, 0);
    chk("std_wr_rd_empty_unf", s_unf, 1);
    chk("std_wr_rd_empty_cnt", s_cnt, 1);
    drive(0, 1, 0, 0, 0, 0);
    chk("std_read_42", s_dout, 8'h42);
    chk("fw_unf_pulse", f_unf, 0);

    // FWFT latency and read-out
    drive(0, 0, 0, 1, 0, 8'h3C);
    chk("fw_lat_valid0", f_valid, 0);
    chk("fw_lat_cnt", f_cnt, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("fw_lat_valid1", f_valid, 1);
    chk("fw_lat_dout", f_dout, 8'h3C);
    drive(0, 0, 0, 0, 1, 0);
    chk("fw_read_empty", f_empty, 1);
    chk("fw_read_valid", f_valid, 0);

    // FWFT write in the same cycle as the last read -> one-cycle bubble
    drive(0, 0, 0, 1, 0, 8'h77);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 8'h5A);
    chk("fw_bubble_valid", f_valid, 0);
    chk("fw_bubble_cnt", f_cnt, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("fw_bubble_valid1", f_valid, 1);
    chk("fw_bubble_dout", f_dout, 8'h5A);
    drive(0, 0, 0, 0, 1, 0);

    // Wrap-around with sustained simultaneous traffic
    for (int i = 0; i < 4; i++) drive(1, 0, 8'(8'h10 + i), 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 8'(8'h14 + i), 1, 1, 8'(8'h14 + i));
      chk("wrap_std_dout", s_dout, 8'(8'h10 + i));
      chk("wrap_std_cnt", s_cnt, 4);
      chk("wrap_fw_dout", f_dout, 8'(8'h11 + i));
      chk("wrap_fw_cnt", f_cnt, 4);
    end
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Full boundary with simultaneous wr/rd
    for (int i = 0; i < 8; i++) drive(1, 0, 8'(8'h20 + i), 1, 0, 8'(8'h20 + i));
    chk("fb_std_full", s_full, 1);
    chk("fb_fw_full", f_full, 1);
    drive(1, 1, 8'hEE, 1, 1, 8'hEE);
    chk("fb_std_cnt", s_cnt, 7);
    chk("fb_std_ovf", s_ovf, 1);
    chk("fb_std_full0", s_full, 0);
    chk("fb_std_dout", s_dout, 8'h20);
    chk("fb_fw_cnt", f_cnt, 7);
    chk("fb_fw_ovf", f_ovf, 1);
    chk("fb_fw_dout", f_dout, 8'h21);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) drive(1, 0, 8'(8'h30 + i), 1, 0, 8'(8'h30 + i));
    @(negedge clk); #2;
    rst = 1'b1;
    s_wr = 0; s_rd = 0; f_wr = 0; f_rd = 0;
    #1;
    chk("mid_rst_std_cnt", s_cnt, 0);
    chk("mid_rst_std_empty", s_empty, 1);
    chk("mid_rst_std_full", s_full, 0);
    chk("mid_rst_std_valid", s_valid, 0);
    chk("mid_rst_fw_cnt", f_cnt, 0);
    chk("mid_rst_fw_valid", f_valid, 0);
    @(negedge clk); #2 rst = 1'b0;
    drive(1, 0, 8'hA5, 1, 0, 8'hA5);
    drive(0, 1, 0, 0, 0, 0);
    chk("post_rst_std_dout", s_dout, 8'hA5);
    chk("post_rst_std_valid", s_valid, 1);
    chk("post_rst_fw_dout", f_dout, 8'hA5);
    chk("post_rst_fw_valid", f_valid, 1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
